// File: rtl/id_stage_pipelined.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_pipelined (with core_pkg)
//  Description : RV32I decode stage: register file with write-back bypass,
//                load-use stall and a valid/ready ID/EX pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================

package core_pkg;
   typedef enum logic [3:0] {
      ALU_ADD = 4'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0, WB_MEM, WB_PC4
   } wb_sel_e;
endpackage

module id_stage_pipelined
   import core_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int NUM_REGS       = 2**REG_ADDR_WIDTH,
   parameter int WB_BYPASS      = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      if_valid_i,
   input  logic [31:0]               instruction_i,
   input  logic [DATA_WIDTH-1:0]     pc_i,
   output logic                      id_ready_o,
   input  logic                      flush_i,
   input  logic                      ex_ready_i,
   input  logic                      WB_RegWrite_i,
   input  logic [REG_ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0]     wr_data_i,
   output logic                      ex_valid_o,
   output logic [DATA_WIDTH-1:0]     pc_o,
   output logic [DATA_WIDTH-1:0]     immediate_o,
   output logic [DATA_WIDTH-1:0]     rd_data1_o,
   output logic [DATA_WIDTH-1:0]     rd_data2_o,
   output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
   output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
   output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
   output logic                      ALUSrcA_o,
   output logic                      ALUSrcB_o,
   output logic                      Branch_o,
   output logic                      Jump_o,
   output logic                      MemWrite_o,
   output logic                      MemRead_o,
   output logic                      RegWrite_o,
   output logic                      illegal_o,
   output alu_op_e                   ALUOp_o,
   output wb_sel_e                   WBSel_o
);

   localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
   localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
   localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
   localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
   localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] c_OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic                      valid;
      logic [DATA_WIDTH-1:0]     pc;
      logic [DATA_WIDTH-1:0]     imm;
      logic [DATA_WIDTH-1:0]     rd1;
      logic [DATA_WIDTH-1:0]     rd2;
      logic [REG_ADDR_WIDTH-1:0] rs1;
      logic [REG_ADDR_WIDTH-1:0] rs2;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      alu_src_a;
      logic                      alu_src_b;
      logic                      branch;
      logic                      jump;
      logic                      mem_write;
      logic                      mem_read;
      logic                      reg_write;
      logic                      illegal;
      alu_op_e                   alu_op;
      wb_sel_e                   wb_sel;
   } id_ex_t;

   function automatic alu_op_e f_alu_op(input logic [2:0] funct3, input logic alt);
      case (funct3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   logic [6:0]                w_opcode;
   logic [2:0]                w_funct3;
   logic [REG_ADDR_WIDTH-1:0] w_rs1;
   logic [REG_ADDR_WIDTH-1:0] w_rs2;
   logic [REG_ADDR_WIDTH-1:0] w_rd;
   logic [31:0]               w_imm_i32;
   logic [31:0]               w_imm_s32;
   logic [31:0]               w_imm_b32;
   logic [31:0]               w_imm_u32;
   logic [31:0]               w_imm_j32;
   logic [DATA_WIDTH-1:0]     w_rd_data1;
   logic [DATA_WIDTH-1:0]     w_rd_data2;
   logic                      w_rs1_used;
   logic                      w_rs2_used;
   logic                      w_hazard;
   logic                      w_advance;
   id_ex_t                    w_dec;
   id_ex_t                    r_bundle;
   logic [DATA_WIDTH-1:0]     r_regs [NUM_REGS];

   assign w_opcode = instruction_i[6:0];
   assign w_funct3 = instruction_i[14:12];
   assign w_rs1    = instruction_i[15 +: REG_ADDR_WIDTH];
   assign w_rs2    = instruction_i[20 +: REG_ADDR_WIDTH];
   assign w_rd     = instruction_i[7  +: REG_ADDR_WIDTH];

   assign w_imm_i32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
   assign w_imm_s32 = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
   assign w_imm_b32 = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                       instruction_i[30:25], instruction_i[11:8], 1'b0};
   assign w_imm_u32 = {instruction_i[31:12], 12'h000};
   assign w_imm_j32 = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                       instruction_i[20], instruction_i[30:21], 1'b0};

   // Register file: x0 is never written, so it reads 0 without a read-side mux.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (WB_RegWrite_i && (wr_addr_i != '0)) begin
         r_regs[wr_addr_i] <= wr_data_i;
      end
   end

   generate
      if (WB_BYPASS != 0) begin : g_bypass
         assign w_rd_data1 = (WB_RegWrite_i && (wr_addr_i != '0) && (wr_addr_i == w_rs1))
                             ? wr_data_i : r_regs[w_rs1];
         assign w_rd_data2 = (WB_RegWrite_i && (wr_addr_i != '0) && (wr_addr_i == w_rs2))
                             ? wr_data_i : r_regs[w_rs2];
      end else begin : g_no_bypass
         assign w_rd_data1 = r_regs[w_rs1];
         assign w_rd_data2 = r_regs[w_rs2];
      end
   endgenerate

   always_comb begin
      w_dec       = '0;
      w_rs1_used  = 1'b0;
      w_rs2_used  = 1'b0;
      w_dec.valid = 1'b1;
      w_dec.pc    = pc_i;
      w_dec.rs1   = w_rs1;
      w_dec.rs2   = w_rs2;
      w_dec.rd    = w_rd;
      w_dec.rd1   = w_rd_data1;
      w_dec.rd2   = w_rd_data2;
      case (w_opcode)
         c_OPC_LUI: begin
            w_dec.imm       = DATA_WIDTH'($signed(w_imm_u32));
            w_dec.alu_src_b = 1'b1;
            w_dec.alu_op    = ALU_PASSB;
            w_dec.reg_write = 1'b1;
         end
         c_OPC_AUIPC: begin
            w_dec.imm       = DATA_WIDTH'($signed(w_imm_u32));
            w_dec.alu_src_a = 1'b1;
            w_dec.alu_src_b = 1'b1;
            w_dec.reg_write = 1'b1;
         end
         c_OPC_JAL: begin
            w_dec.imm       = DATA_WIDTH'($signed(w_imm_j32));
            w_dec.alu_src_a = 1'b1;
            w_dec.alu_src_b = 1'b1;
            w_dec.jump      = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.wb_sel    = WB_PC4;
         end
         c_OPC_JALR: begin
            w_dec.imm       = DATA_WIDTH'($signed(w_imm_i32));
            w_dec.alu_src_b = 1'b1;
            w_dec.jump      = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.wb_sel    = WB_PC4;
            w_rs1_used      = 1'b1;
         end
         c_OPC_BRANCH: begin
            w_dec.imm    = DATA_WIDTH'($signed(w_imm_b32));
            w_dec.branch = 1'b1;
            w_dec.alu_op = ALU_SUB;
            w_rs1_used   = 1'b1;
            w_rs2_used   = 1'b1;
         end
         c_OPC_LOAD: begin
            w_dec.imm       = DATA_WIDTH'($signed(w_imm_i32));
            w_dec.alu_src_b = 1'b1;
            w_dec.mem_read  = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.wb_sel    = WB_MEM;
            w_rs1_used      = 1'b1;
         end
         c_OPC_STORE: begin
            w_dec.imm       = DATA_WIDTH'($signed(w_imm_s32));
            w_dec.alu_src_b = 1'b1;
            w_dec.mem_write = 1'b1;
            w_rs1_used      = 1'b1;
            w_rs2_used      = 1'b1;
         end
         c_OPC_OPIMM: begin
            w_dec.imm       = DATA_WIDTH'($signed(w_imm_i32));
            w_dec.alu_src_b = 1'b1;
            w_dec.reg_write = 1'b1;
            // bit 30 is immediate data except for SRAI
            w_dec.alu_op    = f_alu_op(w_funct3, (w_funct3 == 3'b101) && instruction_i[30]);
            w_rs1_used      = 1'b1;
         end
         c_OPC_OP: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_op    = f_alu_op(w_funct3, instruction_i[30]);
            w_rs1_used      = 1'b1;
            w_rs2_used      = 1'b1;
         end
         default: begin
            w_dec.illegal = 1'b1;
         end
      endcase
   end

   assign w_hazard  = r_bundle.valid && r_bundle.mem_read && (r_bundle.rd != '0) &&
                      ((w_rs1_used && (r_bundle.rd == w_rs1)) ||
                       (w_rs2_used && (r_bundle.rd == w_rs2)));
   assign w_advance = ex_ready_i || !r_bundle.valid;
   assign id_ready_o = flush_i || (w_advance && !w_hazard);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bundle <= '0;
      end else if (flush_i) begin
         r_bundle <= '0;
      end else if (w_advance) begin
         if (w_hazard || !if_valid_i) begin
            r_bundle <= '0;
         end else begin
            r_bundle <= w_dec;
         end
      end
   end

   assign ex_valid_o  = r_bundle.valid;
   assign pc_o        = r_bundle.pc;
   assign immediate_o = r_bundle.imm;
   assign rd_data1_o  = r_bundle.rd1;
   assign rd_data2_o  = r_bundle.rd2;
   assign rs1_addr_o  = r_bundle.rs1;
   assign rs2_addr_o  = r_bundle.rs2;
   assign rd_addr_o   = r_bundle.rd;
   assign ALUSrcA_o   = r_bundle.alu_src_a;
   assign ALUSrcB_o   = r_bundle.alu_src_b;
   assign Branch_o    = r_bundle.branch;
   assign Jump_o      = r_bundle.jump;
   assign MemWrite_o  = r_bundle.mem_write;
   assign MemRead_o   = r_bundle.mem_read;
   assign RegWrite_o  = r_bundle.reg_write;
   assign illegal_o   = r_bundle.illegal;
   assign ALUOp_o     = r_bundle.alu_op;
   assign WBSel_o     = r_bundle.wb_sel;

endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipelined.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage_pipelined
//  Description : Self-checking bench; bypassing and non-bypassing instances
//                share stimulus and are compared against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_id_stage_pipelined;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid_i, flush_i, ex_ready_i, WB_RegWrite_i;
   logic [31:0] instruction_i, pc_i, wr_data_i;
   logic [4:0]  wr_addr_i;

   logic        id_ready_o, ex_valid_o;
   logic [31:0] pc_o, immediate_o, rd_data1_o, rd_data2_o;
   logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
   logic        ALUSrcA_o, ALUSrcB_o, Branch_o, Jump_o, MemWrite_o, MemRead_o, RegWrite_o, illegal_o;
   alu_op_e     ALUOp_o;
   wb_sel_e     WBSel_o;

   logic        nb_id_ready_o, nb_ex_valid_o;
   logic [31:0] nb_pc_o, nb_immediate_o, nb_rd_data1_o, nb_rd_data2_o;
   logic [4:0]  nb_rs1_addr_o, nb_rs2_addr_o, nb_rd_addr_o;
   logic        nb_ALUSrcA_o, nb_ALUSrcB_o, nb_Branch_o, nb_Jump_o;
   logic        nb_MemWrite_o, nb_MemRead_o, nb_RegWrite_o, nb_illegal_o;
   alu_op_e     nb_ALUOp_o;
   wb_sel_e     nb_WBSel_o;

   always #5 clk = ~clk;

   id_stage_pipelined #(.WB_BYPASS(1)) u_dut (
      .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .instruction_i(instruction_i), .pc_i(pc_i),
      .id_ready_o(id_ready_o), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
      .WB_RegWrite_i(WB_RegWrite_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .ex_valid_o(ex_valid_o), .pc_o(pc_o), .immediate_o(immediate_o),
      .rd_data1_o(rd_data1_o), .rd_data2_o(rd_data2_o),
      .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
      .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .Branch_o(Branch_o), .Jump_o(Jump_o),
      .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o), .RegWrite_o(RegWrite_o),
      .illegal_o(illegal_o), .ALUOp_o(ALUOp_o), .WBSel_o(WBSel_o)
   );

   id_stage_pipelined #(.WB_BYPASS(0)) u_dut_nb (
      .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .instruction_i(instruction_i), .pc_i(pc_i),
      .id_ready_o(nb_id_ready_o), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
      .WB_RegWrite_i(WB_RegWrite_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .ex_valid_o(nb_ex_valid_o), .pc_o(nb_pc_o), .immediate_o(nb_immediate_o),
      .rd_data1_o(nb_rd_data1_o), .rd_data2_o(nb_rd_data2_o),
      .rs1_addr_o(nb_rs1_addr_o), .rs2_addr_o(nb_rs2_addr_o), .rd_addr_o(nb_rd_addr_o),
      .ALUSrcA_o(nb_ALUSrcA_o), .ALUSrcB_o(nb_ALUSrcB_o), .Branch_o(nb_Branch_o), .Jump_o(nb_Jump_o),
      .MemWrite_o(nb_MemWrite_o), .MemRead_o(nb_MemRead_o), .RegWrite_o(nb_RegWrite_o),
      .illegal_o(nb_illegal_o), .ALUOp_o(nb_ALUOp_o), .WBSel_o(nb_WBSel_o)
   );

   // ctl = {ALUSrcA, ALUSrcB, Branch, Jump, MemWrite, MemRead, RegWrite, illegal}
   typedef struct packed {
      logic        valid;
      logic [31:0] pc, imm, d1, d2;
      logic [4:0]  rs1, rs2, rd;
      logic [7:0]  ctl;
      logic [3:0]  alu;
      logic [1:0]  wb;
   } exp_t;

   exp_t        m;
   logic [31:0] m_nb_d1, m_nb_d2;
   logic [31:0] m_regs [32];
   logic        last_ready;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F, 7'h0B};
   logic [3:0]  alu_tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic uses_rs1(input logic [31:0] ins);
      return ins[6:0] inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
   endfunction

   function automatic logic uses_rs2(input logic [31:0] ins);
      return ins[6:0] inside {7'h63, 7'h23, 7'h33};
   endfunction

   function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
      exp_t        e;
      logic [31:0] i_imm, s_imm, b_imm, j_imm;
      i_imm = 32'($signed(ins) >>> 20);
      s_imm = (i_imm & ~32'h1F) | ((ins >> 7) & 32'h1F);
      b_imm = (s_imm & ~32'h801) | (((ins >> 7) & 32'h1) << 11);
      j_imm = (32'($signed(ins) >>> 11) & 32'hFFF0_0000) | (ins & 32'h000F_F000)
            | ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
      e       = '0;
      e.valid = 1'b1;
      e.pc    = pc;
      e.rs1   = ins[19:15];
      e.rs2   = ins[24:20];
      e.rd    = ins[11:7];
      e.alu   = ALU_ADD;
      e.wb    = WB_ALU;
      case (ins[6:0])
         7'h37: begin e.imm = ins & 32'hFFFF_F000; e.ctl = 8'b0100_0010; e.alu = ALU_PASSB; end
         7'h17: begin e.imm = ins & 32'hFFFF_F000; e.ctl = 8'b1100_0010; end
         7'h6F: begin e.imm = j_imm; e.ctl = 8'b1101_0010; e.wb = WB_PC4; end
         7'h67: begin e.imm = i_imm; e.ctl = 8'b0101_0010; e.wb = WB_PC4; end
         7'h63: begin e.imm = b_imm; e.ctl = 8'b0010_0000; e.alu = ALU_SUB; end
         7'h03: begin e.imm = i_imm; e.ctl = 8'b0100_0110; e.wb = WB_MEM; end
         7'h23: begin e.imm = s_imm; e.ctl = 8'b0100_1000; end
         7'h13: begin
            e.imm = i_imm; e.ctl = 8'b0100_0010;
            e.alu = (ins[14:12] == 3'd5 && ins[30]) ? ALU_SRA : alu_tab[ins[14:12]];
         end
         7'h33: begin
            e.ctl = 8'b0000_0010;
            if (ins[14:12] == 3'd0 && ins[30])      e.alu = ALU_SUB;
            else if (ins[14:12] == 3'd5 && ins[30]) e.alu = ALU_SRA;
            else                                    e.alu = alu_tab[ins[14:12]];
         end
         default: e.ctl = 8'b0000_0001;
      endcase
      return e;
   endfunction

   task automatic check_outputs();
      chk("ex_valid", ex_valid_o, m.valid);
      chk("pc", pc_o, m.pc);
      chk("imm", immediate_o, m.imm);
      chk("rd_data1", rd_data1_o, m.d1);
      chk("rd_data2", rd_data2_o, m.d2);
      chk("addrs", {rs1_addr_o, rs2_addr_o, rd_addr_o}, {m.rs1, m.rs2, m.rd});
      chk("ctl", {ALUSrcA_o, ALUSrcB_o, Branch_o, Jump_o, MemWrite_o, MemRead_o, RegWrite_o, illegal_o}, m.ctl);
      chk("alu_wb", {ALUOp_o, WBSel_o}, {m.alu, m.wb});
      chk("nb_ex_valid", nb_ex_valid_o, m.valid);
      chk("nb_pc_imm", {nb_pc_o, nb_immediate_o}, {m.pc, m.imm});
      chk("nb_rd_data", {nb_rd_data1_o, nb_rd_data2_o}, {m_nb_d1, m_nb_d2});
      chk("nb_addrs", {nb_rs1_addr_o, nb_rs2_addr_o, nb_rd_addr_o}, {m.rs1, m.rs2, m.rd});
      chk("nb_ctl", {nb_ALUSrcA_o, nb_ALUSrcB_o, nb_Branch_o, nb_Jump_o, nb_MemWrite_o, nb_MemRead_o,
                     nb_RegWrite_o, nb_illegal_o, nb_ALUOp_o, nb_WBSel_o}, {m.ctl, m.alu, m.wb});
   endtask

   task automatic model_reset();
      m       = '0;
      m_nb_d1 = '0;
      m_nb_d2 = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
   endtask

   // Called at posedge+1; drives inputs, checks ready at negedge, checks bundle after the edge.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic er, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd);
      logic        adv, haz, rdy, fwd1, fwd2;
      exp_t        nxt;
      logic [31:0] nb1, nb2;
      if_valid_i = v; instruction_i = ins; pc_i = pc; flush_i = fl;
      ex_ready_i = er; WB_RegWrite_i = we; wr_addr_i = wa; wr_data_i = wd;
      @(negedge clk);
      haz = m.valid && m.ctl[2] && (m.rd != 0) &&
            ((uses_rs1(ins) && m.rd == ins[19:15]) || (uses_rs2(ins) && m.rd == ins[24:20]));
      adv = er || !m.valid;
      rdy = fl || (adv && !haz);
      last_ready = id_ready_o;
      chk("id_ready", id_ready_o, rdy);
      chk("nb_id_ready", nb_id_ready_o, rdy);
      fwd1 = we && (wa != 0) && (wa == ins[19:15]);
      fwd2 = we && (wa != 0) && (wa == ins[24:20]);
      nxt = m; nb1 = m_nb_d1; nb2 = m_nb_d2;
      if (fl || (adv && (haz || !v))) begin
         nxt = '0; nb1 = '0; nb2 = '0;
      end else if (adv) begin
         nxt    = model_decode(ins, pc);
         nb1    = m_regs[ins[19:15]];
         nb2    = m_regs[ins[24:20]];
         nxt.d1 = fwd1 ? wd : nb1;
         nxt.d2 = fwd2 ? wd : nb2;
      end
      @(posedge clk);
      #1;
      m = nxt; m_nb_d1 = nb1; m_nb_d2 = nb2;
      if (we && wa != 0) m_regs[wa] = wd;
      check_outputs();
   endtask

   logic [31:0] held_pc, held_imm;

   initial begin
      rst = 1'b0; if_valid_i = 0; instruction_i = 0; pc_i = 0; flush_i = 0;
      ex_ready_i = 0; WB_RegWrite_i = 0; wr_addr_i = 0; wr_data_i = 0;
      model_reset();
      #2 rst = 1'b1;
      #1 check_outputs();
      chk("rst_ready", id_ready_o, 1'b1);
      @(posedge clk); #1 rst = 1'b0;
      #1 chk("post_rst_ready", id_ready_o, 1'b1);

      // addi x1,x0,5
      cycle(1, 32'h0050_0093, 32'h100, 0, 1, 0, 0, 0);
      chk("addi_valid", ex_valid_o, 1'b1);
      chk("addi_rd", rd_addr_o, 5'd1);
      chk("addi_imm", immediate_o, 32'd5);
      chk("addi_ctl", {RegWrite_o, ALUSrcB_o, MemRead_o}, 3'b110);

      // Same-cycle write-back forwarding and x0 protection
      cycle(0, 0, 0, 0, 1, 1, 5'd7, 32'h1111_1111);
      cycle(1, 32'h0003_8433, 32'h104, 0, 1, 1, 5'd7, 32'hDEAD_BEEF);
      chk("bypass_on", rd_data1_o, 32'hDEAD_BEEF);
      chk("bypass_off", nb_rd_data1_o, 32'h1111_1111);
      cycle(1, 32'h0000_04B3, 32'h108, 0, 1, 1, 5'd0, 32'hCAFE_F00D);
      chk("x0_same_cycle", rd_data1_o, 32'd0);
      cycle(1, 32'h0000_04B3, 32'h10C, 0, 1, 0, 0, 0);
      chk("x0_after", {rd_data1_o, nb_rd_data1_o}, 64'd0);

      // Load-use: lw x2,0(x1) then add x3,x2,x1
      cycle(1, 32'h0000_A103, 32'h110, 0, 1, 0, 0, 0);
      cycle(1, 32'h0011_01B3, 32'h114, 0, 1, 0, 0, 0);
      chk("lu_stall_ready", last_ready, 1'b0);
      chk("lu_bubble", ex_valid_o, 1'b0);
      cycle(1, 32'h0011_01B3, 32'h114, 0, 1, 0, 0, 0);
      chk("lu_resume_ready", last_ready, 1'b1);
      chk("lu_add_regs", {ex_valid_o, rs1_addr_o, rs2_addr_o}, {1'b1, 5'd2, 5'd1});

      // Back-pressure from EX for three cycles
      held_pc = pc_o; held_imm = immediate_o;
      for (int i = 0; i < 3; i++) begin
         cycle(1, 32'h0070_0213, 32'h118, 0, 0, 0, 0, 0);
         chk("stall_ready", last_ready, 1'b0);
         chk("stall_hold", {pc_o, immediate_o}, {held_pc, held_imm});
      end
      cycle(1, 32'h0070_0213, 32'h118, 0, 1, 0, 0, 0);
      chk("release_load", {last_ready, pc_o, immediate_o}, {1'b1, 32'h118, 32'd7});

      // Flush over a stalled bundle, then an illegal word
      cycle(1, 32'h0010_0293, 32'h11C, 1, 0, 0, 0, 0);
      chk("flush_ready", last_ready, 1'b1);
      chk("flush_bubble", ex_valid_o, 1'b0);
      cycle(1, 32'hFFFF_FFFF, 32'h120, 0, 1, 0, 0, 0);
      chk("illegal", {ex_valid_o, illegal_o, RegWrite_o, MemWrite_o}, 4'b1100);

      // Reset asserted in the middle of a stall
      cycle(1, 32'h0050_0093, 32'h124, 0, 0, 0, 0, 0);
      cycle(1, 32'h0050_0093, 32'h128, 0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1 model_reset();
      check_outputs();
      chk("midstall_rst_ready", id_ready_o, 1'b1);
      @(posedge clk); #1 rst = 1'b0;

      // Randomised traffic with small register indices to provoke hazards
      for (int k = 0; k < 600; k++) begin
         logic [31:0] ins;
         ins        = $urandom;
         ins[6:0]   = ops[$urandom_range(0, 10)];
         ins[19:15] = 5'($urandom_range(0, 3));
         ins[24:20] = 5'($urandom_range(0, 3));
         ins[11:7]  = 5'($urandom_range(0, 3));
         cycle($urandom_range(0, 9) < 8, ins, $urandom, $urandom_range(0, 19) == 0,
               $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
- Next-generation decode stage for the RV32I core.
- Combines decode, a parametrised register file with write-back bypass, load-use hazard detection and an ID/EX pipeline register with valid/ready handshake and flush.
- Sits between IF (valid/instruction/pc in, ready out) and EX (registered decoded bundle out, ready in).
- Control types (alu_op_e, wb_sel_e) come from core_pkg.

Parameters:
DATA_WIDTH, 32, datapath, PC and immediate width
REG_ADDR_WIDTH, 5, register address width
NUM_REGS, 2**REG_ADDR_WIDTH, architectural register count
WB_BYPASS, 1, 1 = same-cycle write-back data forwarded to read ports; 0 = pre-write read value returned

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
if_valid_i  input  1  instruction_i/pc_i hold a valid instruction
instruction_i  input  32  instruction word
pc_i  input  DATA_WIDTH  instruction PC
id_ready_o  output  1  ID consumes the IF instruction this cycle
flush_i  input  1  kill the ID instruction and the ID/EX contents (branch/jump redirect)
ex_ready_i  input  1  EX accepts the ID/EX bundle this cycle
WB_RegWrite_i  input  1  register-file write enable
wr_addr_i  input  REG_ADDR_WIDTH  write address
wr_data_i  input  DATA_WIDTH  write data
ex_valid_o  output  1  ID/EX bundle valid
pc_o  output  DATA_WIDTH  registered PC
immediate_o, rd_data1_o, rd_data2_o  output  DATA_WIDTH  registered immediate and operands
rs1_addr_o, rs2_addr_o, rd_addr_o  output  REG_ADDR_WIDTH  registered register indices (for EX forwarding)
ALUSrcA_o, ALUSrcB_o, Branch_o, Jump_o, MemWrite_o, MemRead_o, RegWrite_o, illegal_o  output  1  registered control
ALUOp_o  output  alu_op_e  registered ALU operation
WBSel_o  output  wb_sel_e  registered write-back select

Behaviour:
- Reset (async): all registers in the register file = 0, ex_valid_o = 0, every ID/EX output = 0 / enum reset value.
- Register file:
  - Written on the clock edge when WB_RegWrite_i = 1 and wr_addr_i != 0. Writes to x0 are ignored; x0 always reads 0.
  - Reads are combinational, indexed by instruction[19:15] and instruction[24:20].
  - WB_BYPASS = 1 and a same-cycle write to rs (non-zero) -> read returns wr_data_i.
- Decode: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Immediates sign-extended from I/S/B/U/J formats. U-format = imm[31:12]<<12. B and J formats have bit 0 = 0.
  - Any other opcode -> illegal_o = 1; RegWrite, MemWrite, MemRead, Branch and Jump forced to 0.
- rs1 is "used" for JALR, BRANCH, LOAD, STORE, OP-IMM and OP. rs2 is "used" for BRANCH, STORE and OP.
- Load-use hazard = ex_valid_o & MemRead_o & rd_addr_o != 0 & (rd_addr_o == rs1 used, or rd_addr_o == rs2 used).
- advance = ex_ready_i | ~ex_valid_o.
- id_ready_o = flush_i | (advance & ~hazard). Combinational, no dependence on if_valid_i.
- ID/EX register update, priority order:
  - flush_i -> load bubble, regardless of ex_ready_i.
  - ~advance -> hold all outputs unchanged.
  - hazard -> load bubble; the IF instruction is not consumed.
  - if_valid_i -> load decoded bundle with ex_valid_o = 1.
  - else -> load bubble.
- Bubble = ex_valid_o = 0 with all enables (RegWrite, MemWrite, MemRead, Branch, Jump, illegal) = 0. Data fields are don't-care but deterministic (0).
- Latency: decode is 1 cycle; the bundle appears on the edge after acceptance.
- A stalled hazard resolves the cycle after the load leaves ID/EX. The write-back value then reaches the consumer via the EX forwarding paths, not through this block.
- Reset asserted mid-stall clears ex_valid_o immediately. id_ready_o then = 1, since advance = 1.

Test Plan:
- Reset with ex_valid_o=1 held -> all outputs 0 asynchronously; after deassert, id_ready_o = 1.
- if_valid_i=1, instruction 0x00500093 (addi x1,x0,5), ex_ready_i=1 -> next cycle ex_valid_o=1, rd_addr_o=1, immediate_o=5, RegWrite_o=1, ALUSrcB_o=1, MemRead_o=0.
- Same cycle WB write x7=0xDEADBEEF while decoding 0x00038433 (add x8,x7,x0): WB_BYPASS=1 -> rd_data1_o=0xDEADBEEF; WB_BYPASS=0 -> old x7 value. Separately, write to x0 -> x0 still reads 0.
- 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1):
  - id_ready_o=0 for exactly 1 cycle and a bubble is inserted (ex_valid_o=0).
  - The add issues the following cycle with rs2_addr_o=1, rs1_addr_o=2.
- ex_ready_i=0 for 3 cycles with a valid bundle -> outputs stable and id_ready_o=0; on release, the bundle is consumed and the next instruction loads.
- flush_i=1 with ex_ready_i=0 and a valid bundle -> next cycle ex_valid_o=0 and id_ready_o=1. Instruction 0xFFFFFFFF -> illegal_o=1, RegWrite_o=0, MemWrite_o=0.
